// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle between the issue stage and the multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start_valid;
    logic                 start_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 result_valid;
    logic                 result_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    // Issue side: drives operands and consumes the product.
    modport master (
        output start_valid, a, b, result_ready,
        input  start_ready, result_valid, product, busy
    );

    // Multiplier side.
    modport slave (
        input  start_valid, a, b, result_ready,
        output start_ready, result_valid, product, busy
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add 32x32 unsigned multiplier with valid/ready handshakes,
// plus the 32-bit carry-lookahead adder it uses for the partial-product add.

// Carry-lookahead adder: 4-bit lookahead groups chained group to group.
module cla_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int unsigned NGRP = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Per-group lookahead carries; the group carry-out feeds the next group.
    always_comb begin
        logic cg;
        cg = cin;
        c  = '0;
        for (int k = 0; k < int'(NGRP); k++) begin
            c[4*k]   = cg;
            c[4*k+1] = g[4*k] | (p[4*k] & cg);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
            cg       = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cg);
        end
        c[WIDTH] = cg;
    end

    assign s    = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
endmodule

module shift_add_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   m_q;
    logic [PW-1:0]      p_q;
    logic [PW-1:0]      p_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      product_q;
    logic               start_ready_q;
    logic               result_valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   sum;
    logic               cout;

    // Partial-product add: upper accumulator half plus multiplicand.
    cla_adder #(.WIDTH(WIDTH)) u_cla (
        .a    (p_q[PW-1:WIDTH]),
        .b    (m_q),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // One shift-and-add step; the carry lands in the top bit so nothing is lost.
    always_comb begin
        p_d = {1'b0, p_q[PW-1:WIDTH], p_q[WIDTH-1:1]};
        if (p_q[0]) begin
            p_d = {cout, sum, p_q[WIDTH-1:1]};
        end
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            m_q            <= '0;
            p_q            <= '0;
            cnt_q          <= '0;
            product_q      <= '0;
            start_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_ready_q <= 1'b1;
                    if (bus.start_valid && start_ready_q) begin
                        m_q           <= bus.a;
                        p_q           <= {WIDTH'(0), bus.b};
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_q      <= p_d;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.product      = product_q;
    assign bus.busy         = busy_q;
endmodule
